// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AF_MARGIN = 2;  // almost_full default sits this many entries below DEPTH
  localparam int DEF_AE_THRESH = 1;

  function automatic int ptr_width(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port DEPTH x WIDTH storage: synchronous write, registered read with enable.
// Only the read register is reset; the array itself is never cleared.
module fifo_sync_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset)   q <= '0;
    else if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with registered count/flags and sticky error flags.
// Define FIFO_SYNC_PARAM_FWFT_EN for first-word-fall-through reads; default is 2-stage registered read.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
  parameter int AE_THRESH = DEF_AE_THRESH,
  localparam int AW       = ptr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] AF_C    = AF_THRESH[AW:0];
  localparam logic [AW:0] AE_C    = AE_THRESH[AW:0];

  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, count_n;
  logic             wr_acc, rd_acc, full_n, empty_n, ram_re;
  logic [WIDTH-1:0] ram_q;

  assign wr_acc   = ce && wr_en && !full;
  assign wr_ptr_n = wr_ptr + (AW+1)'(wr_acc);
  assign count_n  = count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);

`ifdef FIFO_SYNC_PARAM_FWFT_EN
  // The RAM read register doubles as the prefetched output word; rd_ptr counts fetched words.
  logic fetch, rd_valid_n;

  assign rd_acc     = ce && rd_en && rd_valid;
  assign fetch      = ce && (rd_ptr != wr_ptr) && (!rd_valid || rd_acc);
  assign rd_ptr_n   = rd_ptr + (AW+1)'(fetch);
  assign rd_valid_n = fetch || (rd_valid && !rd_acc);
  assign full_n     = (count_n == DEPTH_C);
  assign empty_n    = !rd_valid_n;
  assign ram_re     = fetch;
  assign rd_data    = ram_q;

  always_ff @(posedge clock) begin
    if (reset)   rd_valid <= 1'b0;
    else if (ce) rd_valid <= rd_valid_n;
  end
`else
  logic rd_pend;

  assign rd_acc   = ce && rd_en && !empty;
  assign rd_ptr_n = rd_ptr + (AW+1)'(rd_acc);
  assign full_n   = (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]) && (wr_ptr_n[AW] != rd_ptr_n[AW]);
  assign empty_n  = (wr_ptr_n == rd_ptr_n);
  assign ram_re   = rd_acc;

  // A pending word survives a ce=0 stall and is delivered once ce returns.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (ce) begin
      rd_pend  <= rd_acc;
      rd_valid <= rd_pend;
      if (rd_pend) rd_data <= ram_q;
    end else begin
      rd_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (ce) begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      count        <= count_n;
      full         <= full_n;
      empty        <= empty_n;
      almost_full  <= (count_n >= AF_C);
      almost_empty <= (count_n <= AE_C);
      // a new error in the same cycle as clear_err wins
      overflow     <= (overflow  && !clear_err) || (wr_en && full);
      underflow    <= (underflow && !clear_err) || (rd_en && empty);
    end
  end

  fifo_sync_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (rd_ptr[AW-1:0]),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param (WIDTH=32, DEPTH=8, AF=6, AE=1).
module tb_fifo_sync_param;

  localparam int W = 32;
  localparam int D = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ce = 1'b1;
  logic          wr_en = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          full, almost_full, rd_valid, empty, almost_empty, overflow, underflow;
  logic          rd_en = 1'b0;
  logic          clear_err = 1'b0;
  logic [W-1:0]  rd_data;
  logic [3:0]    count;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  fifo_sync_param #(.WIDTH(W), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(1)) dut (
    .clock(clock), .reset(reset), .ce(ce), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .empty(empty), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clear_err(clear_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every word the DUT hands over must match the head of the expected queue.
  always @(negedge clock) begin
`ifdef FIFO_SYNC_PARAM_FWFT_EN
    if (!reset && ce && rd_valid && rd_en) begin
`else
    if (!reset && rd_valid) begin
`endif
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got 0x%0h, expected no word", rd_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got 0x%0h, expected 0x%0h", rd_data, e);
        end
      end
    end
  end

  task automatic drain_wait(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_af", 64'(almost_full), 64'd0);
    chk("rst_ae", 64'(almost_empty), 64'd1);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_unf", 64'(underflow), 64'd0);

`ifdef FIFO_SYNC_PARAM_FWFT_EN
    wr_en = 1'b1; wr_data = 32'h11;
    tick();
    wr_en = 1'b0;
    chk("fwft_valid_k", 64'(rd_valid), 64'd0);
    chk("fwft_count_k", 64'(count), 64'd1);
    tick();
    chk("fwft_valid_k1", 64'(rd_valid), 64'd1);
    chk("fwft_data_k1", 64'(rd_data), 64'h11);
    chk("fwft_empty_k1", 64'(empty), 64'd0);
    exp_q.push_back(32'h11);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("fwft_valid_ack", 64'(rd_valid), 64'd0);
    chk("fwft_empty_ack", 64'(empty), 64'd1);
    chk("fwft_count_ack", 64'(count), 64'd0);
    chk("fwft_unf", 64'(underflow), 64'd0);
    drain_wait("fwft_sb_drained");
`else
    // Fill 0x00..0x07
    for (int i = 0; i < D; i++) begin
      wr_en = 1'b1; wr_data = 32'(i);
      tick();
      chk("fill_count", 64'(count), 64'(i + 1));
      chk("fill_af", 64'(almost_full), 64'((i + 1) >= 6));
      chk("fill_ae", 64'(almost_empty), 64'((i + 1) <= 1));
      chk("fill_full", 64'(full), 64'((i + 1) == D));
    end

    wr_data = 32'hAA;
    tick();
    wr_en = 1'b0;
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd8);
    chk("ovf_unf", 64'(underflow), 64'd0);

    for (int i = 0; i < D; i++) begin
      rd_en = 1'b1;
      exp_q.push_back(32'(i));
      tick();
    end
    rd_en = 1'b0;
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_count", 64'(count), 64'd0);
    drain_wait("drain_sb");
    chk("drain_valid_idle", 64'(rd_valid), 64'd0);

    // Simultaneous read and write on empty
    rd_en = 1'b1; wr_en = 1'b1; wr_data = 32'h55;
    tick();
    wr_en = 1'b0;
    chk("unf_set", 64'(underflow), 64'd1);
    chk("unf_count", 64'(count), 64'd1);
    chk("unf_ovf_sticky", 64'(overflow), 64'd1);
    exp_q.push_back(32'h55);
    tick();
    rd_en = 1'b0;
    drain_wait("unf_sb");

    // Wrap-around with rd_en and wr_en held at full
    for (int i = 0; i < D; i++) begin
      wr_en = 1'b1; wr_data = 32'h100 + 32'(i);
      tick();
    end
    chk("wrap_full", 64'(full), 64'd1);
    for (int j = 0; j < 20; j++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h200 + 32'(j);
      if (j < 8) exp_q.push_back(32'h100 + 32'(j));
      else       exp_q.push_back(32'h200 + 32'(j - 7));
      tick();
      chk("wrap_count", 64'(count), 64'd7);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_unf", 64'(underflow), 64'd0);
    drain_wait("wrap_sb");
    for (int j = 13; j < 20; j++) begin
      rd_en = 1'b1;
      exp_q.push_back(32'h200 + 32'(j));
      tick();
    end
    rd_en = 1'b0;
    chk("wrap_empty", 64'(empty), 64'd1);
    drain_wait("wrap_tail_sb");

    // ce gating
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 32'h31 + 32'(i);
      tick();
    end
    chk("ce_pre_count", 64'(count), 64'd3);
    ce = 1'b0; rd_en = 1'b1; wr_data = 32'hEE;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ce_count", 64'(count), 64'd3);
      chk("ce_ovf", 64'(overflow), 64'd0);
      chk("ce_unf", 64'(underflow), 64'd0);
      chk("ce_valid", 64'(rd_valid), 64'd0);
    end
    ce = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_empty", 64'(empty), 64'd1);
    chk("mrst_valid", 64'(rd_valid), 64'd0);
    chk("mrst_full", 64'(full), 64'd0);

    // Old words must be gone after reset
    wr_en = 1'b1; wr_data = 32'h77;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    exp_q.push_back(32'h77);
    tick();
    rd_en = 1'b0;
    drain_wait("post_rst_sb");
    chk("post_rst_empty", 64'(empty), 64'd1);
`endif

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
